// File: rtl/xbar_port_sched.sv
// Burst-level round-robin scheduler for one crossbar target port.
// A grant is locked for a whole burst; priority rotates past the winner
// once its final beat handshake completes.
module xbar_port_sched #(
  parameter int unsigned N_MST = 16,
  parameter int unsigned LEN_W = 8,
  parameter int unsigned IDX_W = $clog2(N_MST)
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic [N_MST-1:0]       req,
  input  logic [N_MST*LEN_W-1:0] req_len,
  input  logic                   beat_fire,
  output logic [N_MST-1:0]       grant,
  output logic [IDX_W-1:0]       grant_idx,
  output logic                   busy,
  output logic [LEN_W-1:0]       beat_cnt,
  output logic                   burst_done
);

  localparam int unsigned LAST_IDX = N_MST - 1;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_BUSY = 1'b1
  } state_e;

  state_e             state_q,      state_d;
  logic [IDX_W-1:0]   ptr_q,        ptr_d;
  logic [N_MST-1:0]   grant_q,      grant_d;
  logic [IDX_W-1:0]   grant_idx_q,  grant_idx_d;
  logic               busy_q,       busy_d;
  logic [LEN_W-1:0]   beat_cnt_q,   beat_cnt_d;
  logic               burst_done_q, burst_done_d;
  logic [LEN_W-1:0]   len_q,        len_d;

  logic               pick_vld;
  logic [IDX_W-1:0]   pick_idx;
  logic               last_beat;

  // Round-robin pick: first set request scanning upward from the priority pointer.
  always_comb begin
    pick_vld = 1'b0;
    pick_idx = '0;
    for (int unsigned k = 0; k < N_MST; k++) begin
      int unsigned cand;
      cand = 32'(ptr_q) + k;
      if (cand >= N_MST) begin
        cand = cand - N_MST;
      end
      if (!pick_vld && req[cand]) begin
        pick_vld = 1'b1;
        pick_idx = IDX_W'(cand);
      end
    end
  end

  assign last_beat = (beat_cnt_q == len_q);

  // Next-state and registered-output computation.
  always_comb begin
    state_d      = state_q;
    ptr_d        = ptr_q;
    grant_d      = grant_q;
    grant_idx_d  = grant_idx_q;
    busy_d       = busy_q;
    beat_cnt_d   = beat_cnt_q;
    burst_done_d = 1'b0;
    len_d        = len_q;

    unique case (state_q)
      ST_IDLE: begin
        if (pick_vld) begin
          state_d     = ST_BUSY;
          grant_d     = N_MST'(1) << pick_idx;
          grant_idx_d = pick_idx;
          busy_d      = 1'b1;
          beat_cnt_d  = '0;
          len_d       = req_len[pick_idx*LEN_W +: LEN_W];
        end
      end
      ST_BUSY: begin
        // Grant is held regardless of req; only beat handshakes advance the burst.
        if (beat_fire) begin
          if (last_beat) begin
            state_d      = ST_IDLE;
            grant_d      = '0;
            grant_idx_d  = '0;
            busy_d       = 1'b0;
            beat_cnt_d   = '0;
            burst_done_d = 1'b1;
            ptr_d        = (grant_idx_q == IDX_W'(LAST_IDX)) ? '0 : grant_idx_q + IDX_W'(1);
          end else begin
            beat_cnt_d = beat_cnt_q + LEN_W'(1);
          end
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // State and output registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= ST_IDLE;
      ptr_q        <= '0;
      grant_q      <= '0;
      grant_idx_q  <= '0;
      busy_q       <= 1'b0;
      beat_cnt_q   <= '0;
      burst_done_q <= 1'b0;
      len_q        <= '0;
    end else begin
      state_q      <= state_d;
      ptr_q        <= ptr_d;
      grant_q      <= grant_d;
      grant_idx_q  <= grant_idx_d;
      busy_q       <= busy_d;
      beat_cnt_q   <= beat_cnt_d;
      burst_done_q <= burst_done_d;
      len_q        <= len_d;
    end
  end

  assign grant      = grant_q;
  assign grant_idx  = grant_idx_q;
  assign busy       = busy_q;
  assign beat_cnt   = beat_cnt_q;
  assign burst_done = burst_done_q;

endmodule

// File: tb/tb_xbar_port_sched.sv
// Directed testbench for xbar_port_sched with hand-computed expectations.
module tb_xbar_port_sched;

  localparam int unsigned N_MST = 16;
  localparam int unsigned LEN_W = 8;
  localparam int unsigned IDX_W = 4;

  logic                   clk;
  logic                   rst_n;
  logic [N_MST-1:0]       req;
  logic [N_MST*LEN_W-1:0] req_len;
  logic                   beat_fire;
  logic [N_MST-1:0]       grant;
  logic [IDX_W-1:0]       grant_idx;
  logic                   busy;
  logic [LEN_W-1:0]       beat_cnt;
  logic                   burst_done;

  int n_checks;
  int n_fail;

  xbar_port_sched #(.N_MST(N_MST), .LEN_W(LEN_W)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .req        (req),
    .req_len    (req_len),
    .beat_fire  (beat_fire),
    .grant      (grant),
    .grant_idx  (grant_idx),
    .busy       (busy),
    .beat_cnt   (beat_cnt),
    .burst_done (burst_done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Invariants sampled on the falling edge: grant one-hot or zero, grant!=0 iff busy.
  always @(negedge clk) begin
    check("inv_onehot", 32'($onehot0(grant)), 32'd1);
    check("inv_grant_busy", 32'(grant != '0), 32'(busy));
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_len(input int idx, input logic [LEN_W-1:0] len);
    req_len[idx*LEN_W +: LEN_W] = len;
  endtask

  task automatic do_reset();
    rst_n     = 1'b0;
    req       = '0;
    req_len   = '0;
    beat_fire = 1'b0;
    tick();
    tick();
    check("rst_grant", 32'(grant), 32'd0);
    check("rst_idx", 32'(grant_idx), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_cnt", 32'(beat_cnt), 32'd0);
    check("rst_done", 32'(burst_done), 32'd0);
    rst_n = 1'b1;
  endtask

  initial begin
    logic [15:0] pat;
    int          fires;
    bit          done_seen;

    n_checks = 0;
    n_fail   = 0;
    rst_n    = 1'b0;
    req      = '0;
    req_len  = '0;
    beat_fire = 1'b0;

    // Test 1: single 4-beat burst from initiator 0, then pointer moved to 1.
    do_reset();
    req = 16'h0001;
    set_len(0, 8'd3);
    tick();
    check("t1_grant", 32'(grant), 32'h0001);
    check("t1_idx", 32'(grant_idx), 32'd0);
    check("t1_busy", 32'(busy), 32'd1);
    check("t1_cnt0", 32'(beat_cnt), 32'd0);
    req       = '0;
    beat_fire = 1'b1;
    for (int b = 1; b <= 3; b++) begin
      tick();
      check("t1_cnt", 32'(beat_cnt), 32'(b));
      check("t1_hold", 32'(grant), 32'h0001);
    end
    tick();
    check("t1_done", 32'(burst_done), 32'd1);
    check("t1_grant_off", 32'(grant), 32'd0);
    check("t1_busy_off", 32'(busy), 32'd0);
    check("t1_cnt_clr", 32'(beat_cnt), 32'd0);
    req = 16'h0003;
    tick();
    check("t1_done_pulse", 32'(burst_done), 32'd0);
    check("t1_ptr_grant", 32'(grant), 32'h0002);
    check("t1_ptr_idx", 32'(grant_idx), 32'd1);
    tick();
    check("t1_done2", 32'(burst_done), 32'd1);
    beat_fire = 1'b0;

    // Test 2: all request, 1-beat bursts, round-robin 0..15 then 0.
    do_reset();
    req       = 16'hFFFF;
    beat_fire = 1'b1;
    for (int i = 0; i <= 16; i++) begin
      tick();
      check("t2_idx", 32'(grant_idx), 32'(i % 16));
      check("t2_grant", 32'(grant), 32'(1) << (i % 16));
      tick();
      check("t2_gap_busy", 32'(busy), 32'd0);
      check("t2_gap_done", 32'(burst_done), 32'd1);
    end
    beat_fire = 1'b0;

    // Test 3: grant held despite req drop; next grant follows rotated pointer.
    do_reset();
    req = 16'h0020;
    set_len(5, 8'd2);
    set_len(3, 8'd1);
    tick();
    check("t3_grant", 32'(grant), 32'h0020);
    check("t3_idx", 32'(grant_idx), 32'd5);
    req       = 16'h0008;
    beat_fire = 1'b1;
    tick();
    check("t3_hold1", 32'(grant), 32'h0020);
    tick();
    check("t3_hold2", 32'(grant), 32'h0020);
    check("t3_cnt2", 32'(beat_cnt), 32'd2);
    tick();
    check("t3_done", 32'(burst_done), 32'd1);
    check("t3_off", 32'(grant), 32'd0);
    beat_fire = 1'b0;
    tick();
    check("t3_next", 32'(grant), 32'h0008);
    check("t3_next_idx", 32'(grant_idx), 32'd3);

    // Test 4: idle fires ignored; gapped fires in an 8-beat burst.
    do_reset();
    beat_fire = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      check("t4_idle_cnt", 32'(beat_cnt), 32'd0);
      check("t4_idle_busy", 32'(busy), 32'd0);
    end
    beat_fire = 1'b0;
    req = 16'h0004;
    set_len(2, 8'd7);
    tick();
    check("t4_grant", 32'(grant), 32'h0004);
    req       = '0;
    pat       = 16'b1101_1100_1101_0101;
    fires     = 0;
    done_seen = 1'b0;
    for (int c = 0; c < 16 && !done_seen; c++) begin
      beat_fire = pat[c];
      tick();
      if (pat[c]) fires++;
      if (fires == 8) begin
        check("t4_done", 32'(burst_done), 32'd1);
        check("t4_busy_off", 32'(busy), 32'd0);
        done_seen = 1'b1;
      end else begin
        check("t4_cnt", 32'(beat_cnt), 32'(fires));
        check("t4_busy", 32'(busy), 32'd1);
        check("t4_nodone", 32'(burst_done), 32'd0);
      end
    end
    check("t4_done_seen", 32'(done_seen), 32'd1);
    beat_fire = 1'b0;

    // Test 5: asynchronous reset mid-burst, then initiator 0 wins first.
    do_reset();
    req = 16'h0001;
    set_len(0, 8'd5);
    tick();
    beat_fire = 1'b1;
    tick();
    tick();
    check("t5_cnt2", 32'(beat_cnt), 32'd2);
    #2;
    rst_n = 1'b0;
    #1;
    check("t5_async_grant", 32'(grant), 32'd0);
    check("t5_async_busy", 32'(busy), 32'd0);
    check("t5_async_cnt", 32'(beat_cnt), 32'd0);
    beat_fire = 1'b0;
    req       = 16'h8001;
    tick();
    rst_n = 1'b1;
    tick();
    check("t5_grant", 32'(grant), 32'h0001);
    check("t5_idx", 32'(grant_idx), 32'd0);

    // Test 6: maximum-length 256-beat burst, no counter wrap.
    do_reset();
    req = 16'h0100;
    set_len(8, 8'hFF);
    tick();
    check("t6_grant", 32'(grant), 32'h0100);
    set_len(8, 8'h00);
    beat_fire = 1'b1;
    for (int b = 1; b <= 255; b++) begin
      tick();
      check("t6_cnt", 32'(beat_cnt), 32'(b));
      check("t6_busy", 32'(busy), 32'd1);
    end
    tick();
    check("t6_done", 32'(burst_done), 32'd1);
    check("t6_cnt_clr", 32'(beat_cnt), 32'd0);
    check("t6_off", 32'(grant), 32'd0);
    beat_fire = 1'b0;
    req       = '0;
    tick();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
